vend_fsm_ctrl: RTL and testbench

//  Sequencing controller for the vending machine. Owns the transaction state register and the

---
 rtl/vend_fsm_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_vend_fsm_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vend_fsm_ctrl.sv
// Vending transaction sequencer: state, credit accumulator, item/price latch, idle timer, change.
// Latency: all outputs registered, one cycle after the qualifying input; COMPARE/PROCESS take 1 cycle each.
// Backpressure: RETURN_CHANGE holds until change_ack; coins outside RECEIVE_MONEY are bounced via coin_rej.
module vend_fsm_ctrl #(
  parameter logic [4:0] PRICE0      = 5'd5,
  parameter logic [4:0] PRICE1      = 5'd8,
  parameter logic [4:0] PRICE2      = 5'd10,
  parameter logic [4:0] PRICE3      = 5'd15,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       coin_valid,
  input  logic [3:0] coin_val,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [2:0] state,
  output logic [1:0] item,
  output logic [4:0] pop,
  output logic [4:0] money,
  output logic [4:0] change,
  output logic       dispense,
  output logic       refund,
  output logic       coin_rej
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_RECV    = 3'd2,
    S_COMPARE = 3'd3,
    S_PROCESS = 3'd4,
    S_RETURN  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] item_q, item_d;
  logic [4:0] pop_q, pop_d;
  logic [4:0] money_q, money_d;
  logic [4:0] change_q, change_d;
  logic       dispense_q, dispense_d;
  logic       refund_q, refund_d;
  logic       coin_rej_q, coin_rej_d;
  logic [7:0] timer_q, timer_d;

  logic [4:0] price_sel;
  logic [5:0] sum;
  logic [4:0] money_sat;
  logic       timeout_hit;

  always_comb begin
    price_sel = PRICE0;
    case (sel_item)
      2'd0:    price_sel = PRICE0;
      2'd1:    price_sel = PRICE1;
      2'd2:    price_sel = PRICE2;
      default: price_sel = PRICE3;
    endcase
  end

  assign sum         = {1'b0, money_q} + {2'b00, coin_val};
  assign money_sat   = (sum > 6'd31) ? 5'd31 : sum[4:0];
  // Abort on the TIMEOUT_CYC-th consecutive quiet cycle.
  assign timeout_hit = (timer_q == (TIMEOUT_CYC - 8'd1));

  always_comb begin
    state_d    = state_q;
    item_d     = item_q;
    pop_d      = pop_q;
    money_d    = money_q;
    change_d   = change_q;
    refund_d   = refund_q;
    timer_d    = timer_q;
    dispense_d = 1'b0;
    coin_rej_d = coin_valid && (state_q != S_RECV);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SELECT;
          timer_d = 8'd0;
        end
      end
      S_SELECT: begin
        if (cancel) begin
          state_d = S_IDLE;
          timer_d = 8'd0;
        end else if (sel_valid) begin
          item_d  = sel_item;
          pop_d   = price_sel;
          state_d = S_RECV;
          timer_d = 8'd0;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          timer_d = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RECV: begin
        if (cancel) begin
          // A coin landing with the cancel is still returned as part of the refund.
          money_d  = coin_valid ? money_sat : money_q;
          change_d = coin_valid ? money_sat : money_q;
          refund_d = 1'b1;
          state_d  = S_RETURN;
          timer_d  = 8'd0;
        end else if (coin_valid) begin
          money_d = money_sat;
          timer_d = 8'd0;
          state_d = S_COMPARE;
        end else if (timeout_hit) begin
          change_d = money_q;
          refund_d = 1'b1;
          state_d  = S_RETURN;
          timer_d  = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_COMPARE: begin
        if (money_q >= pop_q) begin
          state_d    = S_PROCESS;
          dispense_d = 1'b1;
        end else begin
          state_d = S_RECV;
        end
      end
      S_PROCESS: begin
        change_d = money_q - pop_q;
        state_d  = S_RETURN;
      end
      S_RETURN: begin
        if (change_ack) begin
          money_d  = 5'd0;
          pop_d    = 5'd0;
          item_d   = 2'd0;
          change_d = 5'd0;
          refund_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        item_d   = 2'd0;
        pop_d    = 5'd0;
        money_d  = 5'd0;
        change_d = 5'd0;
        refund_d = 1'b0;
        timer_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      item_q     <= 2'd0;
      pop_q      <= 5'd0;
      money_q    <= 5'd0;
      change_q   <= 5'd0;
      dispense_q <= 1'b0;
      refund_q   <= 1'b0;
      coin_rej_q <= 1'b0;
      timer_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      item_q     <= item_d;
      pop_q      <= pop_d;
      money_q    <= money_d;
      change_q   <= change_d;
      dispense_q <= dispense_d;
      refund_q   <= refund_d;
      coin_rej_q <= coin_rej_d;
      timer_q    <= timer_d;
    end
  end

  assign state    = state_q;
  assign item     = item_q;
  assign pop      = pop_q;
  assign money    = money_q;
  assign change   = change_q;
  assign dispense = dispense_q;
  assign refund   = refund_q;
  assign coin_rej = coin_rej_q;

endmodule

// File: tb/tb_vend_fsm_ctrl.sv
// Bench for vend_fsm_ctrl: directed purchase/cancel/timeout/reset scenarios, then random traffic,
// all checked every cycle against a transaction-level model of the vending rules.
module tb_vend_fsm_ctrl;

  localparam int TMO = 4;
  // Item 2 is priced at 31 so the saturating accumulator can actually reach its ceiling.
  int prices [4] = '{5, 8, 31, 15};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, sel_valid = 1'b0, coin_valid = 1'b0, cancel = 1'b0, change_ack = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic [3:0] coin_val = 4'd0;
  logic [2:0] state;
  logic [1:0] item;
  logic [4:0] pop, money, change;
  logic       dispense, refund, coin_rej;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  vend_fsm_ctrl #(
    .PRICE0(5'd5), .PRICE1(5'd8), .PRICE2(5'd31), .PRICE3(5'd15), .TIMEOUT_CYC(8'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel_valid(sel_valid), .sel_item(sel_item),
    .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel), .change_ack(change_ack),
    .state(state), .item(item), .pop(pop), .money(money), .change(change),
    .dispense(dispense), .refund(refund), .coin_rej(coin_rej)
  );

  // Transaction model: phase names follow the published state numbering.
  localparam int P_IDLE = 0, P_SEL = 1, P_PAY = 2, P_CMP = 3, P_VEND = 4, P_RET = 5;
  int m_phase, m_item, m_pop, m_money, m_change, m_quiet, nxt, credit;
  bit m_disp, m_refund, m_rej;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_item = 0; m_pop = 0; m_money = 0; m_change = 0; m_quiet = 0;
      m_disp = 0; m_refund = 0; m_rej = 0;
    end else begin
      nxt    = m_phase;
      m_disp = 0;
      m_rej  = coin_valid && (m_phase != P_PAY);
      credit = m_money + (coin_valid ? int'(coin_val) : 0);
      if (credit > 31) credit = 31;
      if (m_phase == P_IDLE) begin
        if (start) nxt = P_SEL;
      end else if (m_phase == P_SEL) begin
        if (cancel) nxt = P_IDLE;
        else if (sel_valid) begin
          m_item = int'(sel_item); m_pop = prices[sel_item]; nxt = P_PAY;
        end else if (m_quiet + 1 == TMO) nxt = P_IDLE;
        else m_quiet++;
      end else if (m_phase == P_PAY) begin
        if (cancel) begin
          m_money = credit; m_change = credit; m_refund = 1; nxt = P_RET;
        end else if (coin_valid) begin
          m_money = credit; m_quiet = 0; nxt = P_CMP;
        end else if (m_quiet + 1 == TMO) begin
          m_change = m_money; m_refund = 1; nxt = P_RET;
        end else m_quiet++;
      end else if (m_phase == P_CMP) begin
        if (m_money >= m_pop) begin nxt = P_VEND; m_disp = 1; end
        else nxt = P_PAY;
      end else if (m_phase == P_VEND) begin
        m_change = m_money - m_pop; nxt = P_RET;
      end else if (m_phase == P_RET) begin
        if (change_ack) begin
          m_money = 0; m_pop = 0; m_item = 0; m_change = 0; m_refund = 0; nxt = P_IDLE;
        end
      end
      if (nxt != m_phase) m_quiet = 0;
      m_phase = nxt;
    end
  end

  logic [22:0] exp_v, act_v;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {m_phase[2:0], m_item[1:0], m_pop[4:0], m_money[4:0], m_change[4:0],
               m_disp, m_refund, m_rej};
      act_v = {state, item, pop, money, change, dispense, refund, coin_rej};
      n_total++;
      if (exp_v === act_v) n_pass++;
      else $display("FAIL cycle_model t=%0t dut st=%0d it=%0d pop=%0d mon=%0d chg=%0d d=%0b r=%0b rej=%0b required st=%0d it=%0d pop=%0d mon=%0d chg=%0d d=%0b r=%0b rej=%0b",
                    $time, state, item, pop, money, change, dispense, refund, coin_rej,
                    m_phase, m_item, m_pop, m_money, m_change, m_disp, m_refund, m_rej);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic step(input logic st, input logic sv, input logic [1:0] si, input logic cv,
                      input logic [3:0] cval, input logic cn, input logic ack);
    start = st; sel_valid = sv; sel_item = si; coin_valid = cv; coin_val = cval;
    cancel = cn; change_ack = ack;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 4'd0, 0, 0);
  endtask

  task automatic coin(input logic [3:0] v, input logic cn);
    step(0, 0, 2'd0, 1, v, cn, 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_all_zero", int'({state, item, pop, money, change, dispense, refund, coin_rej}), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_money", int'(money), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Exact payment for item 1.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    chk("buy_select", int'(state), 1);
    step(0, 1, 2'd1, 0, 4'd0, 0, 0);
    chk("buy_pop", int'(pop), 8);
    coin(4'd5, 0);
    chk("buy_cmp1", int'(state), 3);
    idle(1);
    chk("buy_back_to_pay", int'(state), 2);
    coin(4'd3, 0);
    chk("buy_money", int'(money), 8);
    idle(1);
    chk("buy_dispense", int'(dispense), 1);
    idle(1);
    chk("buy_change", int'(change), 0);
    chk("buy_disp_off", int'(dispense), 0);
    idle(1);
    chk("buy_hold_no_ack", int'(state), 5);
    step(0, 0, 2'd0, 0, 4'd0, 0, 1);
    chk("buy_idle", int'(state), 0);

    // Overpay item 0 with a 10 coin.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    step(0, 1, 2'd0, 0, 4'd0, 0, 0);
    coin(4'd10, 0);
    idle(2);
    chk("over_change", int'(change), 5);
    chk("over_refund", int'(refund), 0);
    step(0, 0, 2'd0, 0, 4'd0, 0, 1);
    chk("over_money_clr", int'(money), 0);

    // Cancel on the same cycle as the second coin: that coin joins the refund.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    step(0, 1, 2'd3, 0, 4'd0, 0, 0);
    coin(4'd5, 0);
    idle(1);
    coin(4'd7, 1);
    chk("cancel_change", int'(change), 12);
    chk("cancel_refund", int'(refund), 1);
    step(0, 0, 2'd0, 0, 4'd0, 0, 1);

    // Saturation on item 2 (price 31): 15+15+15 clamps at 31 and buys exactly.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    step(0, 1, 2'd2, 0, 4'd0, 0, 0);
    coin(4'd15, 0); idle(1);
    coin(4'd15, 0); idle(1);
    coin(4'd15, 0);
    chk("sat_money", int'(money), 31);
    idle(2);
    chk("sat_change", int'(change), 0);
    step(0, 0, 2'd0, 0, 4'd0, 0, 1);

    // Payment timeout after exactly TMO quiet cycles.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    step(0, 1, 2'd2, 0, 4'd0, 0, 0);
    coin(4'd2, 0); idle(1);
    idle(TMO - 1);
    chk("tmo_not_yet", int'(state), 2);
    idle(1);
    chk("tmo_return", int'(state), 5);
    chk("tmo_change", int'(change), 2);
    chk("tmo_refund", int'(refund), 1);
    step(0, 0, 2'd0, 0, 4'd0, 0, 1);

    // Selection timeout goes straight back to idle.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    idle(TMO - 1);
    chk("seltmo_not_yet", int'(state), 1);
    idle(1);
    chk("seltmo_idle", int'(state), 0);

    // Coin in idle is bounced, not credited.
    coin(4'd7, 0);
    chk("rej_pulse", int'(coin_rej), 1);
    chk("rej_money", int'(money), 0);
    idle(1);
    chk("rej_clear", int'(coin_rej), 0);

    // Reset while in COMPARE drops the credit.
    step(1, 0, 2'd0, 0, 4'd0, 0, 0);
    step(0, 1, 2'd1, 0, 4'd0, 0, 0);
    coin(4'd5, 0);
    chk("rst_in_cmp", int'(state), 3);
    pulse_reset();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 3, 4'($urandom_range(1, 15)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
